dmem_store_buffer: RTL and testbench
====================================

// Module: dmem_store_buffer
// PURPOSE
//  Posted-write store buffer between the single-cycle MIPS core's data port and the data-memory bus.
//  - Accepts core stores (memwrite/aluout/writedata) in one cycle.
//  - Drains them in order to a valid/ready bus.
//  - Serves core loads combinationally, forwarding the youngest buffered store to the same word.
//  - Stalls the core only when a store arrives and the buffer is full.
// PARAMETERS
//  DEPTH   4   store entries; power of two, >=2
//  AW      32  address width (byte address; bits [1:0] ignored for matching)
//  DW      32  data width
// PORTS
//  clk        in   1     rising-edge clock
//  reset      in   1     asynchronous, active-high reset
//  memwrite   in   1     core store request this cycle
//  aluout     in   AW    core load/store byte address
//  writedata  in   DW    core store data
//  readdata   out  DW    load data to core (combinational)
//  stall      out  1     store not accepted; core holds PC and instr
//  bus_valid  out  1     head entry presented to bus
//  bus_ready  in   1     bus accepts head entry
//  bus_addr   out  AW    head entry address
//  bus_wdata  out  DW    head entry data
//  bus_raddr  out  AW    = aluout (combinational read port)
//  bus_rdata  in   DW    memory read data for bus_raddr (combinational)
//  empty      out  1     no pending stores (fence/drain indicator)
// BEHAVIOUR
//  - Storage: circular FIFO with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
//    Pointers wrap modulo DEPTH.
//  - Reset (async, while high):
//    - head=tail=count=0; entry valids cleared.
//    - bus_valid=0, empty=1, stall=0.
//    - Entry data/addr are don't-care.
//  - Enqueue: memwrite && count!=DEPTH -> write {aluout,writedata} at tail; tail++ on next edge.
//  - Stall: stall = memwrite && (count==DEPTH). Uses registered count.
//    - A same-cycle dequeue does NOT lift the stall; the slot is usable next cycle.
//  - Dequeue:
//    - bus_valid = (count!=0).
//    - bus_addr/bus_wdata come from the head entry.
//    - On bus_valid && bus_ready: head++.
//    - bus_addr/bus_wdata hold stable while bus_valid && !bus_ready.
//  - Count: +1 enqueue only, -1 dequeue only, unchanged on simultaneous enqueue+dequeue.
//  - Latency: store visible on bus_valid the cycle after acceptance (min 1 cycle).
//    - Throughput: 1 store/cycle.
//  - Load path (every cycle, independent of memwrite):
//    - Compare aluout[AW-1:2] against all valid entries.
//    - readdata = data of the youngest matching entry (closest to tail), else bus_rdata.
//    - The head entry still matches during its handshake cycle (popped entry is still valid that cycle).
//  - empty = (count==0); registered-derived, glitch-free.
//  - Reset mid-drain: pending stores are discarded and the bus handshake is abandoned.
//  - bus_ready while bus_valid=0 is ignored.
// CONFIGURATION
//  DMEM_SB_COALESCE_EN defined:
//    - A store whose word address equals the youngest entry (tail-1) overwrites that entry's data in place.
//    - No allocation, no count change, no stall even when full.
//    - Exception: if that entry is the head and is being popped this cycle (bus_valid && bus_ready),
//      allocate a new entry per normal rules.
//  DMEM_SB_COALESCE_EN undefined:
//    - Every accepted store allocates a new entry.
//    - Same-address stores drain as separate bus writes.
// TESTING
//  1. Reset low, bus_ready=0, store 0x10<-0xAAAA_0001 -> next cycle bus_valid=1, bus_addr=0x10, count=1, empty=0.
//  2. bus_ready=0, 4 stores to 0x0,0x4,0x8,0xC, then a 5th to 0x20 -> stall=1 on 5th.
//     Raise bus_ready 1 cycle -> pop 0x0; stall=1 that cycle; 5th accepted next cycle.
//  3. Stores 0x40<-1 then 0x40<-2 buffered, bus_rdata=0xDEAD, load 0x40 -> readdata=2.
//     Load 0x44 -> readdata=0xDEAD.
//  4. bus_ready=1 constant, store every cycle for 10 cycles -> bus writes in order, 1 cycle behind, stall never 1.
//  5. Count=3, assert reset asynchronously mid-cycle -> bus_valid=0, empty=1 immediately.
//     No bus writes after reset release.
//  6. COALESCE_EN: full buffer, youngest=0x80, store 0x80<-7 -> stall=0, count stays DEPTH, drained 0x80 data=7.
//     Without the macro: stall=1.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write store buffer between the core data port
// and the data-memory bus. Stores are queued in a circular FIFO and drained
// in order over a valid/ready handshake. Loads see the youngest buffered
// store to the same word, otherwise the memory read data.
// Optional feature macro: DMEM_SB_COALESCE_EN (merge a store into the
// youngest entry when it targets the same word).
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [AW-1:0] aluout,
    input  logic [DW-1:0] writedata,
    output logic [DW-1:0] readdata,
    output logic          stall,
    output logic          bus_valid,
    input  logic          bus_ready,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [AW-1:0] bus_raddr,
    input  logic [DW-1:0] bus_rdata,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic          full;
    logic          pop;
    logic          push;
    logic          coal_hit;
    logic [PW-1:0] young_idx;

    assign full      = (count_q == FULL_CNT);
    assign bus_valid = (count_q != '0);
    assign empty     = (count_q == '0);
    assign pop       = bus_valid && bus_ready;
    assign young_idx = tail_q - 1'b1;
    assign bus_addr  = addr_q[head_q];
    assign bus_wdata = data_q[head_q];
    assign bus_raddr = aluout;

`ifdef DMEM_SB_COALESCE_EN
    // Merge into the youngest entry unless it is the head leaving this cycle.
    assign coal_hit = memwrite && bus_valid &&
                      (addr_q[young_idx][AW-1:2] == aluout[AW-1:2]) &&
                      !(pop && (young_idx == head_q));
`else
    assign coal_hit = 1'b0;
`endif

    // Stall uses the registered count: a same-cycle pop does not free a slot.
    assign stall = memwrite && full && !coal_hit;
    assign push  = memwrite && !full && !coal_hit;

    // Next-state for pointers, occupancy and entry valids.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        if (pop) begin
            head_d        = head_q + 1'b1;
            vld_d[head_q] = 1'b0;
        end
        if (push) begin
            tail_d        = tail_q + 1'b1;
            vld_d[tail_q] = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state with asynchronous reset; pending stores are discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Entry payload storage; contents are qualified by vld_q so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= aluout;
            data_q[tail_q] <= writedata;
        end
        if (coal_hit) begin
            data_q[young_idx] <= writedata;
        end
    end

    // Load forwarding: walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        readdata = bus_rdata;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (vld_q[idx] && (addr_q[idx][AW-1:2] == aluout[AW-1:2])) begin
                readdata = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed scenarios plus random traffic checked
// against a queue-based reference model; bus writes go through a scoreboard.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_raddr;
    logic [31:0] bus_rdata;
    logic        empty;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];     // reference model contents, oldest first
    ent_t exp_q[$];  // scoreboard of expected bus writes

    int n_chk = 0;
    int n_err = 0;

    dmem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
        .writedata(writedata), .readdata(readdata), .stall(stall),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_raddr(bus_raddr), .bus_rdata(bus_rdata),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One core cycle: drive at negedge, check combinational outputs, advance model.
    task automatic cycle(input logic mw, input logic [31:0] a, input logic [31:0] d,
                         input logic rdy, input logic [31:0] rd);
        logic        pop;
        logic        coal;
        logic        e_stall;
        logic [31:0] e_rd;
        ent_t        y;
        ent_t        n;
        @(negedge clk);
        memwrite  = mw;
        aluout    = a;
        writedata = d;
        bus_ready = rdy;
        bus_rdata = rd;
        #1;
        pop  = (mq.size() != 0) && rdy;
        coal = 1'b0;
`ifdef DMEM_SB_COALESCE_EN
        if (mw && mq.size() != 0) begin
            y = mq[mq.size()-1];
            if (y.a[31:2] == a[31:2] && !(mq.size() == 1 && pop)) coal = 1'b1;
        end
`endif
        e_stall = mw && (mq.size() == DEPTH) && !coal;
        e_rd = rd;
        foreach (mq[i]) begin
            y = mq[i];
            if (y.a[31:2] == a[31:2]) e_rd = y.d;
        end
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        chk("readdata", readdata, e_rd);
        chk("bus_valid", {31'd0, bus_valid}, {31'd0, mq.size() != 0});
        chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        chk("bus_raddr", bus_raddr, a);
        if (mq.size() != 0) begin
            y = mq[0];
            chk("bus_addr_head", bus_addr, y.a);
        end
        if (coal) begin
            mq[mq.size()-1].d       = d;
            exp_q[exp_q.size()-1].d = d;
        end
        if (pop) void'(mq.pop_front());
        if (mw && !coal && !e_stall) begin
            n.a = a;
            n.d = d;
            mq.push_back(n);
            exp_q.push_back(n);
        end
    endtask

    task automatic drain();
        int budget = 30;
        while (mq.size() != 0 && budget > 0) begin
            cycle(1'b0, 32'h100, 32'h0, 1'b1, $urandom);
            budget--;
        end
        if (mq.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: model still holds %0d entries, required 0", mq.size());
        end
    endtask

    // Monitor: every accepted bus write must match the scoreboard front.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #3;
            if (reset === 1'b0 && bus_valid === 1'b1 && bus_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL bus_write: unexpected write addr 0x%08h, none required", bus_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("bus_waddr", bus_addr, e.a);
                    chk("bus_wdata", bus_wdata, e.d);
                end
            end
        end
    end

    initial begin
        logic [31:0] ra;
        reset     = 1'b1;
        memwrite  = 1'b0;
        aluout    = '0;
        writedata = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        #1;
        chk("reset_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("reset_empty", {31'd0, empty}, 32'd1);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single store, then visible on the bus next cycle.
        cycle(1'b1, 32'h10, 32'hAAAA_0001, 1'b0, 32'h1);
        cycle(1'b0, 32'h10, 32'h0, 1'b0, 32'h2);
        drain();

        // Fill, stall on fifth store; a same-cycle pop does not lift it.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 32'h100 + 32'(i), 1'b0, 32'h0);
        cycle(1'b1, 32'h20, 32'h555, 1'b0, 32'h0);
        cycle(1'b1, 32'h20, 32'h555, 1'b1, 32'h0);
        cycle(1'b1, 32'h20, 32'h555, 1'b0, 32'h0);
        drain();

        // Forwarding of the youngest same-word store.
        cycle(1'b1, 32'h40, 32'h1, 1'b0, 32'h0);
        cycle(1'b1, 32'h40, 32'h2, 1'b0, 32'h0);
        cycle(1'b0, 32'h40, 32'h0, 1'b0, 32'hDEAD);
        cycle(1'b0, 32'h43, 32'h0, 1'b0, 32'hDEAD);
        cycle(1'b0, 32'h44, 32'h0, 1'b0, 32'hDEAD);
        drain();

        // Full throughput with ready held high.
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h200 + 32'(i * 4), 32'(i) + 32'h7000, 1'b1, 32'h0);
        drain();

        // Asynchronous reset mid-cycle with three pending stores.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h300 + 32'(i * 4), 32'(i), 1'b0, 32'h0);
        @(negedge clk);
        memwrite = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("async_empty", {31'd0, empty}, 32'd1);
        mq.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h300, 32'h0, 1'b1, 32'hBEEF);

        // Full buffer whose youngest entry is the store target.
        cycle(1'b1, 32'h0, 32'h11, 1'b0, 32'h0);
        cycle(1'b1, 32'h4, 32'h12, 1'b0, 32'h0);
        cycle(1'b1, 32'h8, 32'h13, 1'b0, 32'h0);
        cycle(1'b1, 32'h80, 32'h14, 1'b0, 32'h0);
        cycle(1'b1, 32'h80, 32'h7, 1'b0, 32'h0);
        cycle(1'b0, 32'h80, 32'h0, 1'b0, 32'h9999);
        drain();

        // Random traffic over a small address window to provoke hits and fills.
        for (int i = 0; i < 400; i++) begin
            ra = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            cycle($urandom_range(0, 9) < 6, ra, $urandom,
                  (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8),
                  $urandom);
        end
        drain();
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
